// File: rtl/axi4_master_txn_checker.sv
// axi4_master_txn_checker
//
// Passive checker that watches the five AXI4 channels of a master port.
// It tracks outstanding writes and reads, checks each W burst length
// against the AWLEN accepted on AW, and flags VALID drops and unexpected
// responses. Errors are reported as a sticky vector. Outstanding counts,
// completion counts and the SLVERR count are reported as live counters.
//
// Build option: define AXI4_MON_TIMEOUT_EN to include the response
// watchdog that drives err[7]. Without it, err[7] is tied to 0.
//
// err bit map:
//   [0] write overflow (AW accepted at MAX_OUTSTANDING)
//   [1] W burst with no AW ahead of it
//   [2] WLAST position mismatch
//   [3] unexpected B (nothing outstanding, or data not yet complete)
//   [4] read overflow (AR accepted at MAX_OUTSTANDING)
//   [5] R beat with no read outstanding
//   [6] VALID dropped while stalled on any channel
//   [7] response timeout

module axi4_master_txn_checker #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             awvalid,
  input  logic             awready,
  input  logic [7:0]       awlen,
  input  logic             wvalid,
  input  logic             wready,
  input  logic             wlast,
  input  logic             bvalid,
  input  logic             bready,
  input  logic [1:0]       bresp,
  input  logic             arvalid,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rready,
  input  logic             rlast,
  input  logic [1:0]       rresp,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [31:0]      wr_done_cnt,
  output logic [31:0]      rd_done_cnt,
  output logic [15:0]      slverr_cnt,
  output logic [7:0]       err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // Reject configurations the pointer arithmetic and watchdog cannot handle.
  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (ID_WIDTH < 1) begin : g_bad_id
    $error("ID_WIDTH must be at least 1");
  end

  // Only resp[1] (SLVERR/DECERR) is of interest.
  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{bresp[0], rresp[0]};

  // ---------------------------------------------------------------------
  // Handshakes and channel vectors; bit order {R, AR, B, W, AW}
  // ---------------------------------------------------------------------
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [4:0] valid_vec, ready_vec;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign b_hs  = bvalid  & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid  & rready;

  assign valid_vec = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign ready_vec = {rready, arready, bready, wready, awready};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [7:0]       fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] wr_data_done;   // bursts whose data completed, awaiting B
  logic [8:0]       w_beats;        // beats seen in the current W burst
  logic [4:0]       stalled;        // per channel: VALID high, READY low last edge

  // ---------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic [8:0]  burst_len;
  logic [8:0]  w_beats_inc;
  logic        wr_full, rd_full;
  logic        timeout_hit;

  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_head   = fifo_mem[rd_ptr];
  assign burst_len   = {1'b0, fifo_head} + 9'd1;
  assign w_beats_inc = w_beats + 9'd1;
  assign wr_full     = (wr_outstanding == MAX_CNT);
  assign rd_full     = (rd_outstanding == MAX_CNT);

  logic        fifo_push, fifo_pop;
  logic        wr_inc, wr_dec, data_inc, data_dec, rd_inc, rd_dec;
  logic [8:0]  w_beats_nxt;
  logic [7:0]  err_set;
  logic [7:0]  err_nxt;
  logic [1:0]  slv_inc;
  logic [16:0] slv_sum;

  // Evaluate every handshake against the pre-edge state and decide updates.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    wr_inc      = 1'b0;
    wr_dec      = 1'b0;
    data_inc    = 1'b0;
    data_dec    = 1'b0;
    rd_inc      = 1'b0;
    rd_dec      = 1'b0;
    w_beats_nxt = w_beats;
    err_set     = '0;

    if (aw_hs) begin
      if (!wr_full) begin
        wr_inc    = 1'b1;
        fifo_push = 1'b1;
      end else begin
        err_set[0] = 1'b1;
      end
    end

    if (w_hs) begin
      if (wlast) begin
        w_beats_nxt = '0;
        if (fifo_empty) begin
          err_set[1] = 1'b1;
        end else begin
          fifo_pop = 1'b1;
          if (w_beats_inc != burst_len) err_set[2] = 1'b1;
          else                          data_inc   = 1'b1;
        end
      end else begin
        w_beats_nxt = w_beats_inc;
        // Burst already has all its beats, yet another non-last beat arrived.
        if (!fifo_empty && (w_beats == burst_len)) err_set[2] = 1'b1;
      end
    end

    if (b_hs) begin
      if ((wr_outstanding == '0) || (wr_data_done == '0)) begin
        err_set[3] = 1'b1;
      end else begin
        wr_dec   = 1'b1;
        data_dec = 1'b1;
      end
    end

    if (ar_hs) begin
      if (!rd_full) rd_inc     = 1'b1;
      else          err_set[4] = 1'b1;
    end

    if (r_hs) begin
      if (rd_outstanding == '0) err_set[5] = 1'b1;
      else if (rlast)           rd_dec     = 1'b1;
    end

    if (|(stalled & ~valid_vec)) err_set[6] = 1'b1;

    err_set[7] = timeout_hit;
  end

  // A clear and a new error in the same cycle leave the new error set.
  assign err_nxt = err_clr ? err_set : (err | err_set);

  // B and R can both carry an error response in the same cycle.
  assign slv_inc = 2'(b_hs & bresp[1]) + 2'(r_hs & rresp[1]);
  assign slv_sum = {1'b0, slverr_cnt} + {15'd0, slv_inc};

  // ---------------------------------------------------------------------
  // AWLEN FIFO
  // ---------------------------------------------------------------------

  // Capture AWLEN on accepted AW.
  // NOTE: the storage array has no reset; fifo_cnt and the pointers define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge aclk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= awlen;
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outstanding and completion counters
  // ---------------------------------------------------------------------

  // Write-side tracking: outstanding AWs, completed data bursts, W beats.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_outstanding <= '0;
      wr_data_done   <= '0;
      w_beats        <= '0;
      wr_done_cnt    <= '0;
    end else begin
      case ({wr_inc, wr_dec})
        2'b10:   wr_outstanding <= wr_outstanding + 1'b1;
        2'b01:   wr_outstanding <= wr_outstanding - 1'b1;
        default: wr_outstanding <= wr_outstanding;
      endcase
      case ({data_inc, data_dec})
        2'b10:   wr_data_done <= wr_data_done + 1'b1;
        2'b01:   wr_data_done <= wr_data_done - 1'b1;
        default: wr_data_done <= wr_data_done;
      endcase
      w_beats <= w_beats_nxt;
      if (wr_dec) wr_done_cnt <= wr_done_cnt + 32'd1;
    end
  end

  // Read-side tracking: outstanding ARs and completed read bursts.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_outstanding <= '0;
      rd_done_cnt    <= '0;
    end else begin
      case ({rd_inc, rd_dec})
        2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
        2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
        default: rd_outstanding <= rd_outstanding;
      endcase
      if (rd_dec) rd_done_cnt <= rd_done_cnt + 32'd1;
    end
  end

  // Saturating SLVERR/DECERR response counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) slverr_cnt <= '0;
    else          slverr_cnt <= slv_sum[16] ? 16'hFFFF : slv_sum[15:0];
  end

  // ---------------------------------------------------------------------
  // VALID stability and sticky errors
  // ---------------------------------------------------------------------

  // Remember which channels were stalled so a VALID drop is caught next edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) stalled <= '0;
    else          stalled <= valid_vec & ~ready_vec;
  end

  // Sticky error vector.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err <= '0;
    else          err <= err_nxt;
  end

  // ---------------------------------------------------------------------
  // Response watchdog
  // ---------------------------------------------------------------------
`ifdef AXI4_MON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt, to_cnt_nxt;

  // Count idle cycles while anything is outstanding; hold at the limit.
  always_comb begin
    to_cnt_nxt = to_cnt;
    if (b_hs || r_hs || ((wr_outstanding == '0) && (rd_outstanding == '0)))
      to_cnt_nxt = '0;
    else if (to_cnt != TO_MAX)
      to_cnt_nxt = to_cnt + 1'b1;
  end

  // Holding at the limit keeps re-raising err[7] after a clear.
  assign timeout_hit = (to_cnt_nxt == TO_MAX);

  // Watchdog counter register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) to_cnt <= '0;
    else          to_cnt <= to_cnt_nxt;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_master_txn_checker.sv
// Self-checking bench for axi4_master_txn_checker.
// Each scenario builds a stimulus table with the hand-derived expected
// outputs per cycle; the expectation goes on a scoreboard queue when the
// row is driven and is popped and compared once the edge has been taken.

module tb_axi4_master_txn_checker;

  localparam int MAX_OUT = 8;
  localparam int TO_CYC  = 16;
  localparam int CW      = $clog2(MAX_OUT + 1);

  // Channel bit positions in stimulus vectors.
  localparam logic [4:0] AW = 5'b00001;
  localparam logic [4:0] W  = 5'b00010;
  localparam logic [4:0] B  = 5'b00100;
  localparam logic [4:0] AR = 5'b01000;
  localparam logic [4:0] R  = 5'b10000;

  typedef struct packed {
    logic [4:0] v;
    logic [4:0] rdy;
    logic [7:0] len;
    logic       wl;
    logic       rl;
    logic [1:0] br;
    logic [1:0] rr;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic [CW-1:0] wr_o;
    logic [CW-1:0] rd_o;
    logic [31:0]   wd;
    logic [31:0]   rdn;
    logic [15:0]   slv;
    logic [7:0]    er;
  } exp_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          awvalid, awready, wvalid, wready, wlast;
  logic          bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  logic [7:0]    awlen;
  logic [1:0]    bresp, rresp;
  logic          err_clr;
  logic [CW-1:0] wr_outstanding, rd_outstanding;
  logic [31:0]   wr_done_cnt, rd_done_cnt;
  logic [15:0]   slverr_cnt;
  logic [7:0]    err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 aclk = ~aclk;

  axi4_master_txn_checker #(
    .ID_WIDTH        (4),
    .MAX_OUTSTANDING (MAX_OUT),
    .TIMEOUT_CYCLES  (TO_CYC)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .awvalid        (awvalid),
    .awready        (awready),
    .awlen          (awlen),
    .wvalid         (wvalid),
    .wready         (wready),
    .wlast          (wlast),
    .bvalid         (bvalid),
    .bready         (bready),
    .bresp          (bresp),
    .arvalid        (arvalid),
    .arready        (arready),
    .rvalid         (rvalid),
    .rready         (rready),
    .rlast          (rlast),
    .rresp          (rresp),
    .err_clr        (err_clr),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .wr_done_cnt    (wr_done_cnt),
    .rd_done_cnt    (rd_done_cnt),
    .slverr_cnt     (slverr_cnt),
    .err            (err)
  );

  // Handshake row: every asserted VALID is accepted.
  function automatic stim_t hs(logic [4:0] v, logic [7:0] len = 8'd0, logic wl = 1'b0,
                               logic rl = 1'b0, logic [1:0] br = 2'b00,
                               logic [1:0] rr = 2'b00, logic clr = 1'b0);
    stim_t s;
    s.v = v; s.rdy = v; s.len = len; s.wl = wl; s.rl = rl;
    s.br = br; s.rr = rr; s.clr = clr;
    return s;
  endfunction

  // Row with independent VALID and READY vectors.
  function automatic stim_t stall(logic [4:0] v, logic [4:0] rdy);
    stim_t s;
    s = '0;
    s.v = v; s.rdy = rdy;
    return s;
  endfunction

  function automatic exp_t mk(int wr, int rd, int wd, int rdn, int slv, logic [7:0] er);
    exp_t e;
    e.wr_o = CW'(wr); e.rd_o = CW'(rd); e.wd = 32'(wd); e.rdn = 32'(rdn);
    e.slv = 16'(slv); e.er = er;
    return e;
  endfunction

  task automatic apply(stim_t s);
    awvalid = s.v[0]; awready = s.rdy[0]; awlen = s.len;
    wvalid  = s.v[1]; wready  = s.rdy[1]; wlast = s.wl;
    bvalid  = s.v[2]; bready  = s.rdy[2]; bresp = s.br;
    arvalid = s.v[3]; arready = s.rdy[3];
    rvalid  = s.v[4]; rready  = s.rdy[4]; rlast = s.rl; rresp = s.rr;
    err_clr = s.clr;
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    apply('0);
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    aresetn = 1'b0;
    s_q.push_back('0);             e_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(AW | AR | B, 8'd2, 1'b0, 1'b0, 2'b10));
                                   e_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL reset[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
    aresetn = 1'b1;
  endtask

  task automatic test_write_burst();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    s_q.push_back(hs(AW, 8'd3));          e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W));                 e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W));                 e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W));                 e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W, 8'd0, 1'b1));     e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(B));                 e_q.push_back(mk(0, 0, 1, 0, 0, 8'h00));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL write_burst[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_back_to_back();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    s_q.push_back(hs(AW, 8'd0));            e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(AW | W, 8'd1, 1'b1));  e_q.push_back(mk(2, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W));                   e_q.push_back(mk(2, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W, 8'd0, 1'b1));       e_q.push_back(mk(2, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(B));                   e_q.push_back(mk(1, 0, 1, 0, 0, 8'h00));
    s_q.push_back(hs(B));                   e_q.push_back(mk(0, 0, 2, 0, 0, 8'h00));
    s_q.push_back(hs(AW, 8'd0));            e_q.push_back(mk(1, 0, 2, 0, 0, 8'h00));
    s_q.push_back(hs(W, 8'd0, 1'b1));       e_q.push_back(mk(1, 0, 2, 0, 0, 8'h00));
    s_q.push_back(hs(AW | B, 8'd0));        e_q.push_back(mk(1, 0, 3, 0, 0, 8'h00));
    s_q.push_back(hs(W, 8'd0, 1'b1));       e_q.push_back(mk(1, 0, 3, 0, 0, 8'h00));
    s_q.push_back(hs(B));                   e_q.push_back(mk(0, 0, 4, 0, 0, 8'h00));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_wlast_mismatch();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    s_q.push_back(hs(AW, 8'd3));              e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W));                     e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W));                     e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W, 8'd0, 1'b1));         e_q.push_back(mk(1, 0, 0, 0, 0, 8'h04));
    s_q.push_back(hs(5'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
                                              e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    // B before data complete, in the same cycle as a clear: the new error stays.
    s_q.push_back(hs(B, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
                                              e_q.push_back(mk(1, 0, 0, 0, 0, 8'h08));
    s_q.push_back(hs(AW, 8'd0));              e_q.push_back(mk(2, 0, 0, 0, 0, 8'h08));
    s_q.push_back(hs(W));                     e_q.push_back(mk(2, 0, 0, 0, 0, 8'h08));
    // Second non-last beat of a one-beat burst.
    s_q.push_back(hs(W));                     e_q.push_back(mk(2, 0, 0, 0, 0, 8'h0C));
    s_q.push_back(hs(W, 8'd0, 1'b1));         e_q.push_back(mk(2, 0, 0, 0, 0, 8'h0C));
    // W burst with the AWLEN FIFO empty.
    s_q.push_back(hs(W, 8'd0, 1'b1));         e_q.push_back(mk(2, 0, 0, 0, 0, 8'h0E));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL wlast_mismatch[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_write_overflow();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    for (int k = 1; k <= MAX_OUT; k++) begin
      s_q.push_back(hs(AW, 8'd0));            e_q.push_back(mk(k, 0, 0, 0, 0, 8'h00));
    end
    s_q.push_back(hs(W, 8'd0, 1'b1));         e_q.push_back(mk(8, 0, 0, 0, 0, 8'h00));
    // AW at full with a same-cycle B: flagged, B still retires one.
    s_q.push_back(hs(AW | B, 8'd0));          e_q.push_back(mk(7, 0, 1, 0, 0, 8'h01));
    s_q.push_back(hs(W, 8'd0, 1'b1));         e_q.push_back(mk(7, 0, 1, 0, 0, 8'h01));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL write_overflow[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_read_overflow();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    for (int k = 1; k <= MAX_OUT + 1; k++) begin
      s_q.push_back(hs(AR));
      e_q.push_back(mk(0, (k > MAX_OUT) ? MAX_OUT : k, 0, 0, 0, (k > MAX_OUT) ? 8'h10 : 8'h00));
    end
    s_q.push_back(hs(5'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
                                              e_q.push_back(mk(0, 8, 0, 0, 0, 8'h00));
    s_q.push_back(hs(R));                     e_q.push_back(mk(0, 8, 0, 0, 0, 8'h00));
    s_q.push_back(hs(AR | R, 8'd0, 1'b0, 1'b1));
                                              e_q.push_back(mk(0, 7, 0, 1, 0, 8'h10));
    for (int k = 1; k <= 7; k++) begin
      s_q.push_back(hs(R, 8'd0, 1'b0, 1'b1)); e_q.push_back(mk(0, 7 - k, 0, 1 + k, 0, 8'h10));
    end
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL read_overflow[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_unexpected_resp();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    s_q.push_back(hs(B));                                    e_q.push_back(mk(0, 0, 0, 0, 1 - 1, 8'h08));
    s_q.push_back(hs(R, 8'd0, 1'b0, 1'b1, 2'b00, 2'b10));   e_q.push_back(mk(0, 0, 0, 0, 1, 8'h28));
    s_q.push_back(hs(B, 8'd0, 1'b0, 1'b0, 2'b11));          e_q.push_back(mk(0, 0, 0, 0, 2, 8'h28));
    s_q.push_back(hs(B | R, 8'd0, 1'b0, 1'b1, 2'b10, 2'b11));
                                                             e_q.push_back(mk(0, 0, 0, 0, 4, 8'h28));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL unexpected_resp[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_valid_drop();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    s_q.push_back(stall(AW, 5'b0));           e_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s_q.push_back('0);                        e_q.push_back(mk(0, 0, 0, 0, 0, 8'h40));
    s_q.push_back(hs(5'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
                                              e_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s_q.push_back(stall(AR, 5'b0));           e_q.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(AR));                    e_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    s_q.push_back('0);                        e_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    s_q.push_back(stall(W, 5'b0));            e_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    s_q.push_back('0);                        e_q.push_back(mk(0, 1, 0, 0, 0, 8'h40));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL valid_drop[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_mid_reset();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    // Partial burst, then an asynchronous reset between clock edges.
    apply(hs(AW | AR, 8'd3)); step();
    apply(hs(W));             step();
    apply(hs(W | B));         step();
    apply('0);
    #2;
    aresetn = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    e = sb.pop_front();
    n_checks++;
    if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
      n_errors++;
      $display("FAIL async_reset: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected all zero",
               wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err);
    end
    step();
    aresetn = 1'b1;
    s_q.push_back(hs(AW, 8'd0));              e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(W, 8'd0, 1'b1));         e_q.push_back(mk(1, 0, 0, 0, 0, 8'h00));
    s_q.push_back(hs(B));                     e_q.push_back(mk(0, 0, 1, 0, 0, 8'h00));
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL mid_reset[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  task automatic test_timeout();
    stim_t s_q[$];
    exp_t  e_q[$];
    exp_t  e;
    do_reset();
    s_q.push_back(hs(AR));                    e_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
`ifdef AXI4_MON_TIMEOUT_EN
    // Watchdog reaches its limit on the 16th idle edge after the AR.
    for (int k = 1; k < TO_CYC; k++) begin
      s_q.push_back('0);                      e_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    end
    s_q.push_back('0);                        e_q.push_back(mk(0, 1, 0, 0, 0, 8'h80));
    // Counter holds at the limit, so a clear is overridden.
    s_q.push_back(hs(5'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
                                              e_q.push_back(mk(0, 1, 0, 0, 0, 8'h80));
    s_q.push_back(hs(R, 8'd0, 1'b0, 1'b1));   e_q.push_back(mk(0, 0, 0, 1, 0, 8'h80));
    s_q.push_back(hs(5'b0, 8'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
                                              e_q.push_back(mk(0, 0, 0, 1, 0, 8'h00));
`else
    for (int k = 0; k < 3 * TO_CYC; k++) begin
      s_q.push_back('0);                      e_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    end
    s_q.push_back(hs(R, 8'd0, 1'b0, 1'b1));   e_q.push_back(mk(0, 0, 0, 1, 0, 8'h00));
`endif
    for (int i = 0; i < s_q.size(); i++) begin
      apply(s_q[i]);
      sb.push_back(e_q[i]);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err} !== e) begin
        n_errors++;
        $display("FAIL timeout[%0d]: observed wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h; expected wr_out=%0d rd_out=%0d wr_done=%0d rd_done=%0d slverr=%0d err=%02h",
                 i, wr_outstanding, rd_outstanding, wr_done_cnt, rd_done_cnt, slverr_cnt, err,
                 e.wr_o, e.rd_o, e.wd, e.rdn, e.slv, e.er);
      end
    end
    apply('0);
  endtask

  initial begin
    aresetn = 1'b0;
    apply('0);
    test_reset();
    test_write_burst();
    test_back_to_back();
    test_wlast_mismatch();
    test_write_overflow();
    test_read_overflow();
    test_unexpected_resp();
    test_valid_drop();
    test_mid_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
